rd_result_collector: RTL
========================

Name: rd_result_collector

Overview:
- Return path for the operand demux: takes one issued ALU operation and tracks its opcode and destination register.
- Selects the matching functional-unit result when that unit signals completion, then presents one writeback to the register file under a valid/ready handshake.
- One operation outstanding at a time. Detects illegal opcodes, spurious unit completions and units that never respond.

Parameters:
- N, 16, data width of results and writeback data
- SEL_LINE, 4, opcode width
- ADDR_W, 4, register address width
- TIMEOUT, 64, cycles allowed in WAIT before abandoning the operation; legal range 2..2^16

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- issue_valid  input  1  operation issued this cycle
- issue_ready  output  1  collector can accept an issue
- op_opcode  input  SEL_LINE  0=add 1=sub 2=mul 3=div 4=and 5=or 6=xor
- rd_addr  input  ADDR_W  destination register of the issued op
- add_res, sub_res, mul_res, div_res, and_res, or_res, xor_res  input  N each  unit results
- res_valid  input  7  one bit per unit, index = opcode; bit high means that unit's result is valid this cycle
- wb_valid  output  1  writeback request
- wb_ready  input  1  register file accepts the writeback
- wb_addr  output  ADDR_W  writeback register address
- wb_data  output  N  writeback data
- busy  output  1  high when state is not IDLE
- err_opcode  output  1  one-cycle pulse: illegal opcode issued
- err_spurious  output  1  one-cycle pulse: unexpected res_valid bit seen
- err_timeout  output  1  one-cycle pulse: operation abandoned

Behaviour:
- Reset (rst high at a clock edge):
  - state becomes IDLE; timer, wb_addr, wb_data and all error outputs become 0.
  - wb_valid and busy are 0.
  - issue_ready is forced 0 while rst is high.
  - Reset mid-operation discards the pending op with no writeback and no error pulse.
- issue_ready = (state==IDLE) and not rst. It is combinational from state only and never depends on issue_valid.
- IDLE, on issue_valid:
  - Capture opcode and rd_addr.
  - If opcode > 6: pulse err_opcode the next cycle and stay in IDLE.
  - Otherwise go to WAIT and clear the timer.
- WAIT:
  - If res_valid[opcode] is high: register the selected unit result into wb_data, register the captured rd into wb_addr, and go to WB.
  - Otherwise increment the timer. When the timer equals TIMEOUT-1: pulse err_timeout and go to IDLE with no writeback.
  - If a result and the timeout coincide, the result wins and no error is raised.
- WB:
  - wb_valid=1. wb_addr and wb_data are held stable until wb_valid && wb_ready, then go to IDLE.
  - wb_ready has no combinational path to issue_ready, so the next issue is accepted at the earliest one cycle after the handshake.
  - wb_ready is ignored when wb_valid is 0.
- err_spurious pulses one cycle after any cycle in which a res_valid bit is high, except the expected bit in WAIT. Spurious data is never written back.
  - In WAIT, the expected bit is still consumed normally even if other bits are high in the same cycle.
- Latency: issue accepted at cycle t, expected result at t+k (k≥1), wb_valid first high at t+k+1.
- All registered outputs change only on clk edges. Result selection is a pure mux by the captured opcode; no arithmetic is performed on the data.
- rd_addr=0 is written back like any other address; suppression is the register file's responsibility.

Test Plan:
- Add flow:
  - Stimulus: reset; issue op=0, rd=5; add_res=16'h1234 with res_valid=7'b0000001 two cycles later; wb_ready=1.
  - Required: wb_valid for exactly 1 cycle, wb_addr=5, wb_data=16'h1234; then IDLE with issue_ready=1.
- Backpressure:
  - Stimulus: op=3 (div), rd=9; div_res=16'h00FF valid after 10 cycles; wb_ready low for 4 cycles after wb_valid rises.
  - Required: wb_valid, wb_addr=9 and wb_data=16'h00FF stable through the stall; issue_ready=0 until one cycle after the handshake.
- Spurious result:
  - Stimulus: op=2 (mul) issued; res_valid=7'b0000001 (add) arrives first, then mul valid with mul_res=16'h0040.
  - Required: one err_spurious pulse; writeback data=16'h0040; add data never appears on wb_data.
- Timeout:
  - Stimulus: TIMEOUT=8; op=4 issued; no res_valid.
  - Required: err_timeout pulses on the 8th WAIT cycle; no wb_valid; back to IDLE. Result+timeout in the same cycle -> writeback, no err_timeout.
- Illegal opcode:
  - Stimulus: issue op=4'hA.
  - Required: err_opcode pulse; busy stays 0.
- Reset in WB:
  - Stimulus: assert rst while wb_valid=1 and wb_ready=0.
  - Required: wb_valid=0 the next cycle, outputs 0, no error pulses.

Source files
------------

// File: rtl/rd_result_collector.sv
// Result collector: tracks one issued ALU op, picks the matching unit result on
// completion and presents a single valid/ready writeback; flags bad opcodes, stray completions and timeouts.
module rd_result_collector #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int ADDR_W   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [SEL_LINE-1:0] op_opcode,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [N-1:0]        add_res,
  input  logic [N-1:0]        sub_res,
  input  logic [N-1:0]        mul_res,
  input  logic [N-1:0]        div_res,
  input  logic [N-1:0]        and_res,
  input  logic [N-1:0]        or_res,
  input  logic [N-1:0]        xor_res,
  input  logic [6:0]          res_valid,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [N-1:0]        wb_data,
  output logic                busy,
  output logic                err_opcode,
  output logic                err_spurious,
  output logic                err_timeout
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t              state_q, state_d;
  logic [SEL_LINE-1:0] op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [N-1:0]        wb_data_q, wb_data_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                err_op_q, err_op_d;
  logic                err_sp_q, err_sp_d;
  logic                err_to_q, err_to_d;
  logic [N-1:0]        sel_data;
  logic [6:0]          exp_mask;
  logic [6:0]          stray;

  // Pure select by the captured opcode; exp_mask is the completion bit we wait for.
  always_comb begin
    sel_data = '0;
    exp_mask = '0;
    case (op_q)
      SEL_LINE'(0): begin sel_data = add_res; exp_mask = 7'b0000001; end
      SEL_LINE'(1): begin sel_data = sub_res; exp_mask = 7'b0000010; end
      SEL_LINE'(2): begin sel_data = mul_res; exp_mask = 7'b0000100; end
      SEL_LINE'(3): begin sel_data = div_res; exp_mask = 7'b0001000; end
      SEL_LINE'(4): begin sel_data = and_res; exp_mask = 7'b0010000; end
      SEL_LINE'(5): begin sel_data = or_res;  exp_mask = 7'b0100000; end
      SEL_LINE'(6): begin sel_data = xor_res; exp_mask = 7'b1000000; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    timer_d   = timer_q;
    err_op_d  = 1'b0;
    err_to_d  = 1'b0;
    stray     = (state_q == S_WAIT) ? (res_valid & ~exp_mask) : res_valid;
    err_sp_d  = |stray;

    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          op_d = op_opcode;
          rd_d = rd_addr;
          if (op_opcode > SEL_LINE'(6)) begin
            err_op_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            timer_d = '0;
          end
        end
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle takes priority over the timeout.
        if (|(res_valid & exp_mask)) begin
          wb_data_d = sel_data;
          wb_addr_d = rd_q;
          state_d   = S_WB;
        end else if (timer_q == TMAX) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      timer_q   <= '0;
      err_op_q  <= 1'b0;
      err_sp_q  <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      timer_q   <= timer_d;
      err_op_q  <= err_op_d;
      err_sp_q  <= err_sp_d;
      err_to_q  <= err_to_d;
    end
  end

  assign issue_ready  = (state_q == S_IDLE) && !rst;
  assign wb_valid     = (state_q == S_WB);
  assign busy         = (state_q != S_IDLE);
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign err_opcode   = err_op_q;
  assign err_spurious = err_sp_q;
  assign err_timeout  = err_to_q;

endmodule
